// File: rtl/mem_arb_pkg.sv
// Shared state/owner types and cache-block geometry for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, WR, FILL} arb_state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam int unsigned BLOCK_WORDS    = 8;
  localparam int unsigned WORD_OFF_W     = $clog2(BLOCK_WORDS);
  localparam int unsigned BLOCK_OFF_BITS = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one pipelined memory between I-cache and D-cache miss handlers:
// 8-word block fills (one read issued per cycle) and single-word D-cache write-throughs.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned BLOCK_WORDS = mem_arb_pkg::BLOCK_WORDS,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req_fill,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic                           d_req_fill,
  input  logic                           d_req_wr,
  input  logic [ADDR_WIDTH-1:0]          d_addr,
  input  logic [15:0]                    d_wdata,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [15:0]                    mem_data_in,
  input  logic [15:0]                    mem_data_out,
  input  logic                           mem_data_valid,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_done,
  output logic                           d_done,
  output logic                           d_wr_ack,
  output logic                           busy
);

  import mem_arb_pkg::*;

  localparam int unsigned WOFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_W  = WOFF_W + 1;
  localparam int unsigned BASE_W = ADDR_WIDTH - BLOCK_OFF_BITS;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [BASE_W-1:0]     base_q, base_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      recv_cnt_q, recv_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;

  // Block-offset and halfword-select bits are don't-care on the request side.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[BLOCK_OFF_BITS-1:0], d_addr[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_data_in = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    d_wr_ack    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Fixed priority: write-through, then D fill, then I fill.
        if (d_req_wr) begin
          wr_addr_d = {d_addr[ADDR_WIDTH-1:1], 1'b0};
          wr_data_d = d_wdata;
          state_d   = WR;
        end else if (d_req_fill || i_req_fill) begin
          owner_d     = d_req_fill ? OWN_D : OWN_I;
          base_d      = d_req_fill ? d_addr[ADDR_WIDTH-1:BLOCK_OFF_BITS]
                                   : i_addr[ADDR_WIDTH-1:BLOCK_OFF_BITS];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      WR: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr_q;
        mem_data_in = wr_data_q;
        d_wr_ack    = 1'b1;
        state_d     = IDLE;
      end
      FILL: begin
        if (issue_cnt_q < CNT_FULL) begin
          mem_enable  = 1'b1;
          mem_addr    = {base_q, issue_cnt_q[WOFF_W-1:0], 1'b0};
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        // Reads return in issue order, so the receive count is the word offset.
        if (mem_data_valid) begin
          fill_data  = mem_data_out;
          fill_word  = recv_cnt_q[WOFF_W-1:0];
          i_fill_we  = (owner_q == OWN_I);
          d_fill_we  = (owner_q == OWN_D);
          recv_cnt_d = recv_cnt_q + CNT_W'(1);
          if (recv_cnt_q == CNT_LAST) begin
            i_done  = (owner_q == OWN_I);
            d_done  = (owner_q == OWN_D);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  a_block_geometry: assert property (@(posedge clk)
    (WOFF_W == WORD_OFF_W) && (BLOCK_OFF_BITS == WOFF_W + 1));
  a_valid_outstanding: assert property (@(posedge clk) disable iff (rst)
    (state_q == FILL && mem_data_valid) |-> (recv_cnt_q < issue_cnt_q));
  a_read_latency: assert property (@(posedge clk) disable iff (rst)
    (state_q == FILL && mem_data_valid) |-> $past(mem_enable && !mem_wr, MEM_LATENCY));
  a_d_req_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_req_fill && d_req_wr));

endmodule
